// File: rtl/key_expand_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_ctrl
//  Description : Sequencer for a registered single-round key-step datapath.
//                On start it runs NR key steps from the cipher key and
//                generates the Rcon sequence itself. Every round key is kept
//                in an (NR+1)-entry register store, which the round datapath
//                reads through an indexed, registered read port. Decryption
//                reads the indices in reverse order.
//  Revision    : 1.0  initial release
// ============================================================================
module key_expand_ctrl #(
    parameter int          NR        = 10,
    parameter int          KS_LAT    = 1,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [127:0]   key_in,
    output logic           busy,
    output logic           done,
    output logic           keys_valid,
    output logic [127:0]   ks_key_in,
    output logic [31:0]    ks_rcon,
    input  logic [127:0]   ks_key_out,
    input  logic [3:0]     rd_idx,
    output logic [127:0]   rd_key,
    output logic           rd_err
);

    // Round counter wide enough to hold NR; step counter covers KS_LAT <= 3.
    localparam int             RW     = $clog2(NR + 1);
    localparam logic [RW-1:0]  c_NR   = RW'(NR);
    localparam logic [RW-1:0]  c_ONE  = RW'(1);
    localparam logic [1:0]     c_LAT  = 2'(KS_LAT);
    localparam logic [31:0]    c_NR32 = 32'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_round;
    logic [1:0]      r_cnt;
    logic [7:0]      r_rcon;
    logic            r_busy;
    logic            r_done;
    logic            r_keys_valid;
    logic [127:0]    r_ks_key_in;
    logic [31:0]     r_ks_rcon;
    logic [127:0]    r_rk [0:NR];
    logic [127:0]    r_rd_key;
    logic            r_rd_err;

    logic [7:0]      w_xtime;
    logic            w_rd_oob;

    // Next Rcon byte: multiply by x in GF(2^8) with the AES polynomial.
    assign w_xtime  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_rd_oob = ({28'd0, rd_idx} > c_NR32);

    // Expansion sequencer: owns state, counters, key store and datapath drive.
    // ks_key_in / ks_rcon are registered so they stay stable for a whole step;
    // ks_key_in is loaded with the key just written, i.e. rk[round-1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_round      <= '0;
            r_cnt        <= '0;
            r_rcon       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_ks_key_in  <= '0;
            r_ks_rcon    <= '0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort has priority over start when both are raised
                    if (start && !abort) begin
                        r_rk[0]      <= key_in;
                        r_round      <= c_ONE;
                        r_rcon       <= RCON_INIT;
                        r_cnt        <= '0;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_ks_key_in  <= key_in;
                        r_ks_rcon    <= {RCON_INIT, 24'h0};
                        r_state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (abort) begin
                        // Partially written entries stay but are flagged invalid.
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_keys_valid <= 1'b0;
                        r_cnt        <= '0;
                        r_ks_key_in  <= '0;
                        r_ks_rcon    <= '0;
                    end else if (r_cnt == c_LAT) begin
                        r_rk[r_round] <= ks_key_out;
                        r_cnt         <= '0;
                        r_rcon        <= w_xtime;
                        if (r_round == c_NR) begin
                            r_state     <= S_FIN;
                            r_busy      <= 1'b0;
                            r_ks_key_in <= '0;
                            r_ks_rcon   <= '0;
                        end else begin
                            r_round     <= r_round + c_ONE;
                            r_ks_key_in <= ks_key_out;
                            r_ks_rcon   <= {w_xtime, 24'h0};
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_FIN: begin
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read port; out-of-range indices return zero and flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key <= '0;
            r_rd_err <= 1'b0;
        end else begin
            r_rd_key <= w_rd_oob ? '0 : r_rk[rd_idx];
            r_rd_err <= w_rd_oob;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign ks_key_in  = r_ks_key_in;
    assign ks_rcon    = r_ks_rcon;
    assign rd_key     = r_rd_key;
    assign rd_err     = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_key_expand_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_expand_ctrl
//  Description : Bench for key_expand_ctrl. Two instances (KS_LAT=1 and 2),
//                each fed by a behavioural AES key-step stub. Expected round
//                keys come from a plain AES-128 key-expansion model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_expand_ctrl;

    localparam logic [127:0] c_FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] c_FIPS_K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] c_FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         start1, start2;

    logic         busy1, done1, kv1, rd_err1;
    logic [127:0] ks_key_in1, ks_key_out1, rd_key1;
    logic [31:0]  ks_rcon1;
    logic         busy2, done2, kv2, rd_err2;
    logic [127:0] ks_key_in2, ks_key_out2, rd_key2;
    logic [31:0]  ks_rcon2;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox  [0:255];
    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_k [0:10];
    logic [127:0] pipe1;
    logic [127:0] pipe2 [0:1];

    always #5 clk = ~clk;

    key_expand_ctrl #(.NR(10), .KS_LAT(1), .RCON_INIT(8'h01)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .key_in(key_in),
        .busy(busy1), .done(done1), .keys_valid(kv1),
        .ks_key_in(ks_key_in1), .ks_rcon(ks_rcon1), .ks_key_out(ks_key_out1),
        .rd_idx(rd_idx), .rd_key(rd_key1), .rd_err(rd_err1)
    );

    key_expand_ctrl #(.NR(10), .KS_LAT(2), .RCON_INIT(8'h01)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .key_in(key_in),
        .busy(busy2), .done(done2), .keys_valid(kv2),
        .ks_key_in(ks_key_in2), .ks_rcon(ks_rcon2), .ks_key_out(ks_key_out2),
        .rd_idx(rd_idx), .rd_key(rd_key2), .rd_err(rd_err2)
    );

    // ---------------- behavioural AES helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ rc;
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bx  = 8'(x);
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        exp_k[0] = key;
        for (int r = 1; r <= 10; r++) begin
            exp_k[r] = ks_step(exp_k[r-1], {rcon_tab[r-1], 24'h0});
        end
    endtask

    // ---------------- key-step datapath stubs ----------------
    always @(posedge clk) begin
        pipe1    <= ks_step(ks_key_in1, ks_rcon1);
        pipe2[0] <= ks_step(ks_key_in2, ks_rcon2);
        pipe2[1] <= pipe2[0];
    end
    assign ks_key_out1 = pipe1;
    assign ks_key_out2 = pipe2[1];

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_pulse(input int which, input logic [127:0] key);
        @(negedge clk);
        key_in = key;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Counts edges after the start edge until done; -1 if the bound expires.
    task automatic wait_done(input int which, input int first_edge, output int edge_n);
        edge_n = -1;
        for (int n = first_edge; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if ((which == 1 && done1) || (which == 2 && done2)) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic rd(input int idx);
        @(negedge clk);
        rd_idx = 4'(idx);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; start1 = 1'b0; start2 = 1'b0;
        key_in = '0; rd_idx = '0;
        #12;
        n_checks++;
        if ({busy1, done1, kv1, rd_err1} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy1, done1, kv1, rd_err1});
        end
        n_checks++;
        if (ks_key_in1 !== '0 || ks_rcon1 !== '0) begin
            n_errors++;
            $display("FAIL reset_ks: got %h/%h expected 0/0", ks_key_in1, ks_rcon1);
        end
        n_checks++;
        if (rd_key1 !== '0) begin
            n_errors++;
            $display("FAIL reset_rd_key: got %h expected 0", rd_key1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fips();
        logic [31:0] rlog [$];
        logic [31:0] last = '0;
        int busy_cnt = 0;
        int edge_n = -1;
        model_expand(c_FIPS_KEY);
        start_pulse(1, c_FIPS_KEY);
        n_checks++;
        if (busy1 !== 1'b1 || kv1 !== 1'b0) begin
            n_errors++;
            $display("FAIL fips_start_flags: got busy=%b kv=%b expected 1 0", busy1, kv1);
        end
        for (int n = 1; n <= 60; n++) begin
            if (busy1) begin
                busy_cnt++;
                if (ks_rcon1 != last) begin
                    n_checks++;
                    if (ks_key_in1 !== exp_k[rlog.size() % 11]) begin
                        n_errors++;
                        $display("FAIL fips_ks_key_in r%0d: got %h expected %h",
                                 rlog.size(), ks_key_in1, exp_k[rlog.size() % 11]);
                    end
                    rlog.push_back(ks_rcon1);
                    last = ks_rcon1;
                end
            end
            @(posedge clk);
            #1;
            if (done1) begin
                edge_n = n;
                break;
            end
        end
        n_checks++;
        if (edge_n != 21) begin
            n_errors++;
            $display("FAIL fips_done_edge: got %0d expected 21", edge_n);
        end
        n_checks++;
        if (busy_cnt != 20) begin
            n_errors++;
            $display("FAIL fips_busy_cycles: got %0d expected 20", busy_cnt);
        end
        n_checks++;
        if (kv1 !== 1'b1) begin
            n_errors++;
            $display("FAIL fips_keys_valid: got %b expected 1", kv1);
        end
        n_checks++;
        if (rlog.size() != 10) begin
            n_errors++;
            $display("FAIL fips_rcon_count: got %0d expected 10", rlog.size());
        end
        for (int i = 0; i < rlog.size() && i < 10; i++) begin
            n_checks++;
            if (rlog[i] !== {rcon_tab[i], 24'h0}) begin
                n_errors++;
                $display("FAIL fips_rcon[%0d]: got %h expected %h", i, rlog[i], {rcon_tab[i], 24'h0});
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done1 !== 1'b0 || kv1 !== 1'b1) begin
            n_errors++;
            $display("FAIL fips_done_pulse: got done=%b kv=%b expected 0 1", done1, kv1);
        end
        rd(1);
        n_checks++;
        if (rd_key1 !== c_FIPS_K1) begin
            n_errors++;
            $display("FAIL fips_rk1: got %h expected %h", rd_key1, c_FIPS_K1);
        end
        rd(10);
        n_checks++;
        if (rd_key1 !== c_FIPS_K10) begin
            n_errors++;
            $display("FAIL fips_rk10: got %h expected %h", rd_key1, c_FIPS_K10);
        end
        rd(0);
        n_checks++;
        if (rd_key1 !== c_FIPS_KEY || rd_err1 !== 1'b0) begin
            n_errors++;
            $display("FAIL fips_rk0: got %h err=%b expected %h err=0", rd_key1, rd_err1, c_FIPS_KEY);
        end
        rd(11);
        n_checks++;
        if (rd_key1 !== '0 || rd_err1 !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_idx11: got %h err=%b expected 0 err=1", rd_key1, rd_err1);
        end
        rd(15);
        n_checks++;
        if (rd_key1 !== '0 || rd_err1 !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_idx15: got %h err=%b expected 0 err=1", rd_key1, rd_err1);
        end
        // reverse order, as a decryption consumer would read
        for (int i = 10; i >= 0; i--) begin
            rd(i);
            n_checks++;
            if (rd_key1 !== exp_k[i] || rd_err1 !== 1'b0) begin
                n_errors++;
                $display("FAIL fips_rev_rk%0d: got %h expected %h", i, rd_key1, exp_k[i]);
            end
        end
    endtask

    task automatic test_random_keys();
        int edge_n;
        for (int t = 0; t < 3; t++) begin
            logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key);
            start_pulse(1, key);
            wait_done(1, 1, edge_n);
            n_checks++;
            if (edge_n != 21) begin
                n_errors++;
                $display("FAIL rand%0d_done_edge: got %0d expected 21", t, edge_n);
            end
            for (int k = 0; k < 11; k++) begin
                int i = int'($urandom_range(0, 10));
                rd(i);
                n_checks++;
                if (rd_key1 !== exp_k[i]) begin
                    n_errors++;
                    $display("FAIL rand%0d_rk%0d: got %h expected %h", t, i, rd_key1, exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int edge_n;
        int seen_done = 0;
        model_expand(c_FIPS_KEY);
        start_pulse(1, c_FIPS_KEY);
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || kv1 !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_flags: got busy=%b kv=%b expected 0 0", busy1, kv1);
        end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1 || kv1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_errors++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", seen_done);
        end
        // abort together with start in IDLE: start must be ignored
        @(negedge clk);
        key_in = c_FIPS_KEY; start1 = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_start_idle: got busy=%b expected 0", busy1);
        end
        start_pulse(1, c_FIPS_KEY);
        wait_done(1, 1, edge_n);
        n_checks++;
        if (edge_n != 21 || kv1 !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_rerun_done: got edge %0d kv=%b expected 21 1", edge_n, kv1);
        end
        for (int i = 0; i <= 10; i++) begin
            rd(i);
            n_checks++;
            if (rd_key1 !== exp_k[i]) begin
                n_errors++;
                $display("FAIL abort_rerun_rk%0d: got %h expected %h", i, rd_key1, exp_k[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int edge_n;
        model_expand(c_FIPS_KEY);
        start_pulse(1, c_FIPS_KEY);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
        end
        key_in = {$urandom, $urandom, $urandom, $urandom} ^ c_FIPS_KEY ^ 128'h1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1, 7, edge_n);
        n_checks++;
        if (edge_n != 21) begin
            n_errors++;
            $display("FAIL busy_start_done_edge: got %0d expected 21", edge_n);
        end
        rd(10);
        n_checks++;
        if (rd_key1 !== c_FIPS_K10) begin
            n_errors++;
            $display("FAIL busy_start_rk10: got %h expected %h", rd_key1, c_FIPS_K10);
        end
        rd(0);
        n_checks++;
        if (rd_key1 !== c_FIPS_KEY) begin
            n_errors++;
            $display("FAIL busy_start_rk0: got %h expected %h", rd_key1, c_FIPS_KEY);
        end
    endtask

    task automatic test_ks_lat2();
        int edge_n;
        for (int t = 0; t < 2; t++) begin
            logic [127:0] key = (t == 0) ? c_FIPS_KEY : {$urandom, $urandom, $urandom, $urandom};
            model_expand(key);
            start_pulse(2, key);
            wait_done(2, 1, edge_n);
            n_checks++;
            if (edge_n != 31 || kv2 !== 1'b1) begin
                n_errors++;
                $display("FAIL lat2_%0d_done: got edge %0d kv=%b expected 31 1", t, edge_n, kv2);
            end
            for (int i = 0; i <= 10; i++) begin
                rd(i);
                n_checks++;
                if (rd_key2 !== exp_k[i]) begin
                    n_errors++;
                    $display("FAIL lat2_%0d_rk%0d: got %h expected %h", t, i, rd_key2, exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start_pulse(1, c_FIPS_KEY);
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, done1, kv1, rd_err1} !== 4'b0000 || ks_key_in1 !== '0
            || ks_rcon1 !== '0 || rd_key1 !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_async: got busy=%b done=%b kv=%b ks=%h rc=%h rd=%h expected all 0",
                     busy1, done1, kv1, ks_key_in1, ks_rcon1, rd_key1);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", seen);
        end
        rd(0);
        n_checks++;
        if (rd_key1 !== '0 || kv1 !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_store_clear: got %h kv=%b expected 0 0", rd_key1, kv1);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_random_keys();
        test_abort();
        test_start_while_busy();
        test_ks_lat2();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
